// File: rtl/lbist_controller.sv
// LBIST sequencer: for each configured seed, sends the seed to the LFSR and the hash count
// to the MISR, then compares the returned signature against the golden value.
module lbist_controller #(
    parameter int SEED_BITS           = 32,
    parameter int SIGNATURE_BITS      = 32,
    parameter int NUM_SEEDS           = 4,
    parameter int MAX_OUTPUTS_TO_HASH = 32,
    parameter int LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH),
    parameter logic [NUM_SEEDS*SEED_BITS-1:0]      SEEDS      = '0,
    parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] SIGNATURES = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lbist_req_val,
    output logic                      lbist_req_rdy,
    output logic                      lbist_resp_val,
    output logic [NUM_SEEDS-1:0]      lbist_resp_msg,
    input  logic                      lbist_resp_rdy,
    output logic                      lfsr_req_val,
    output logic [SEED_BITS-1:0]      lfsr_req_msg,
    input  logic                      lfsr_req_rdy,
    output logic                      misr_req_val,
    output logic [LBIST_MSG_BITS:0]   misr_req_msg,
    input  logic                      misr_req_rdy,
    input  logic                      misr_resp_val,
    input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
    output logic                      misr_resp_rdy
);

    // state    | meaning
    // IDLE     | waiting for a start request
    // SEND     | issuing seed idx to LFSR and hash count to MISR
    // WAIT_SIG | waiting for the MISR signature of seed idx
    // DONE     | presenting the pass/fail vector to the requester
    typedef enum logic [1:0] {IDLE, SEND, WAIT_SIG, DONE} state_t;

    localparam int IDX_BITS = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SEEDS - 1);

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic                  lfsr_sent_q, lfsr_sent_d;
    logic                  misr_sent_q, misr_sent_d;
    logic [NUM_SEEDS-1:0]  result_q, result_d;

    logic                  lfsr_fire;
    logic                  misr_fire;
    logic                  sig_match;

    // Outputs depend only on registered state; reset low masks every handshake output.
    assign lbist_req_rdy  = reset && (state_q == IDLE);
    assign lfsr_req_val   = reset && (state_q == SEND) && !lfsr_sent_q;
    assign misr_req_val   = reset && (state_q == SEND) && !misr_sent_q;
    assign misr_resp_rdy  = reset && (state_q == WAIT_SIG);
    assign lbist_resp_val = reset && (state_q == DONE);
    assign lbist_resp_msg = result_q;
    assign lfsr_req_msg   = SEEDS[int'(idx_q)*SEED_BITS +: SEED_BITS];
    assign misr_req_msg   = (LBIST_MSG_BITS+1)'(MAX_OUTPUTS_TO_HASH);

    assign lfsr_fire = lfsr_req_val && lfsr_req_rdy;
    assign misr_fire = misr_req_val && misr_req_rdy;
    assign sig_match = (misr_resp_msg == SIGNATURES[int'(idx_q)*SIGNATURE_BITS +: SIGNATURE_BITS]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lfsr_sent_d = lfsr_sent_q;
        misr_sent_d = misr_sent_q;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (lbist_req_val) begin
                    idx_d       = '0;
                    result_d    = '0;
                    lfsr_sent_d = 1'b0;
                    misr_sent_d = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if ((lfsr_sent_q || lfsr_fire) && (misr_sent_q || misr_fire)) begin
                    lfsr_sent_d = 1'b0;
                    misr_sent_d = 1'b0;
                    state_d     = WAIT_SIG;
                end else begin
                    lfsr_sent_d = lfsr_sent_q || lfsr_fire;
                    misr_sent_d = misr_sent_q || misr_fire;
                end
            end
            WAIT_SIG: begin
                if (misr_resp_val) begin
                    result_d[idx_q] = sig_match;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                if (lbist_resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lfsr_sent_q <= 1'b0;
            misr_sent_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lfsr_sent_q <= lfsr_sent_d;
            misr_sent_q <= misr_sent_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: doc/lbist_controller.md
Name: lbist_controller

Overview:
- Test sequencer at the controller end of the LBIST pattern-generator and MISR interfaces.
- On a start request, for each of NUM_SEEDS seeds it:
  - sends the seed to the LFSR pattern generator;
  - tells the MISR how many CUT outputs to hash;
  - collects the resulting signature and compares it against a golden signature.
- Returns a per-seed pass/fail vector to the requester, e.g. a scan or host register block.

Parameters:
- SEED_BITS, 32, width of one LFSR seed.
- SIGNATURE_BITS, 32, width of one MISR signature.
- NUM_SEEDS, 4, number of seeds per LBIST run (≥1).
- MAX_OUTPUTS_TO_HASH, 32, CUT outputs hashed per seed (≥1).
- LBIST_MSG_BITS, $clog2(MAX_OUTPUTS_TO_HASH), count field width minus one.
- SEEDS, '0, packed NUM_SEEDS*SEED_BITS vector; seed i = bits [i*SEED_BITS +: SEED_BITS].
- SIGNATURES, '0, packed NUM_SEEDS*SIGNATURE_BITS vector; golden signature i, same packing.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- lbist_req_val  input  1  start-run request valid (no payload).
- lbist_req_rdy  output  1  controller can accept a start request.
- lbist_resp_val  output  1  run result valid.
- lbist_resp_msg  output  NUM_SEEDS  bit i = 1 iff signature i matched its golden value.
- lbist_resp_rdy  input  1  requester accepts result.
- lfsr_req_val  output  1  seed valid to LFSR.
- lfsr_req_msg  output  SEED_BITS  seed i.
- lfsr_req_rdy  input  1  LFSR accepts seed.
- misr_req_val  output  1  hash-count request valid to MISR.
- misr_req_msg  output  LBIST_MSG_BITS+1  constant MAX_OUTPUTS_TO_HASH.
- misr_req_rdy  input  1  MISR accepts count.
- misr_resp_val  input  1  signature valid from MISR.
- misr_resp_msg  input  SIGNATURE_BITS  signature.
- misr_resp_rdy  output  1  controller accepts signature.

Behaviour:
- Handshakes:
  - A transfer occurs on a posedge where val && rdy.
  - A producer holds val and msg stable until the transfer occurs.
- Registered state:
  - state ∈ {IDLE, SEND, WAIT_SIG, DONE};
  - seed index idx (range 0..NUM_SEEDS-1);
  - flags lfsr_sent and misr_sent;
  - result[NUM_SEEDS-1:0].
- Outputs are decoded combinationally from state and flags only; there is no combinational path from any input val/rdy to any output.
- Reset (reset==0 at posedge):
  - state=IDLE, idx=0, flags=0, result=0.
  - While reset is low, all val/rdy outputs are forced 0.
  - Reset mid-run aborts immediately with no partial response; any MISR signature arriving later is left un-accepted until the next run reaches WAIT_SIG.
- IDLE:
  - lbist_req_rdy=1.
  - On transfer: idx=0, result=0, flags=0, next state SEND.
- SEND:
  - lfsr_req_val = !lfsr_sent, with lfsr_req_msg = SEEDS[idx].
  - misr_req_val = !misr_sent, with misr_req_msg = MAX_OUTPUTS_TO_HASH.
  - Both channels may transfer in the same cycle and may complete in either order; each transfer sets its flag.
  - When both transfers are complete (including the case where the last one transfers this cycle), next state is WAIT_SIG and both flags are cleared.
  - Minimum SEND occupancy is 1 cycle.
- WAIT_SIG:
  - misr_resp_rdy=1.
  - On transfer, result[idx] = (misr_resp_msg == SIGNATURES[idx]).
  - If idx == NUM_SEEDS-1, next state is DONE; otherwise idx++ and next state is SEND.
  - misr_resp_val arriving in any other state is not accepted (rdy=0).
- DONE:
  - lbist_resp_val=1, lbist_resp_msg=result.
  - On transfer, next state is IDLE; result is held until the next start.
- lbist_req_val in any state other than IDLE is ignored.
- Latency:
  - start transfer → first lfsr/misr val: 1 cycle;
  - last signature transfer → lbist_resp_val: 1 cycle.
- Throughput: back-to-back runs are allowed; IDLE lasts at least one cycle after the DONE transfer.

Test Plan:
- NUM_SEEDS=2, SEEDS={32'hDEADBEEF, 32'h0000ACE1}, SIGNATURES={32'h12345678, 32'hCAFEF00D}; all sinks always ready; MISR returns 32'hCAFEF00D then 32'h12345678 → lfsr msgs 32'h0000ACE1 then 32'hDEADBEEF, misr_req_msg=32 each time, lbist_resp_msg=2'b11.
- Same config, second signature returned as 32'h12345679 → lbist_resp_msg=2'b01.
- Backpressure:
  - lfsr_req_rdy held low 5 cycles, misr_req_rdy accepted in cycle 1 → misr_req_val drops after 1 transfer and never re-asserts; lfsr_req_val and lfsr_req_msg stay stable until accepted; WAIT_SIG is entered the cycle after the lfsr transfer.
  - lbist_resp_rdy held low 3 cycles → lbist_resp_val and lbist_resp_msg held stable.
- Reset mid-run:
  - reset driven low during WAIT_SIG for seed 1 → the next cycle shows lbist_req_rdy=0 and all other val/rdy outputs 0.
  - After release: lbist_req_rdy=1; a new start re-issues seed 0.
- misr_resp_val=1 asserted during IDLE and SEND → misr_resp_rdy=0 and no result change; lbist_req_val pulsed during WAIT_SIG → no effect.
- NUM_SEEDS=1 edge case: single seed with matching signature → lbist_resp_msg=1'b1; two back-to-back runs each complete with an IDLE gap of 1 cycle.
